pipe_pcu: RTL
=============

// Module: pipe_pcu
//
// PURPOSE
//  PC generation stage directly upstream of the instruction fetch unit. Owns the
//  architectural fetch PC and drives cur_pc into fetch; the fetch unit consumes
//  cur_pc and reports if_stall. Handles sequential advance, taken branches with a
//  MIPS delay slot, exception entry and ERET return.
//
// PARAMETERS
//  RESET_PC  32'hBFC0_0000  PC loaded on reset
//  EXC_VEC   32'hBFC0_0380  PC loaded on exception entry
//
// PORTS
//  clk            in   1   clock; all state updates on posedge
//  resetn         in   1   asynchronous, active-low reset
//  if_stall       in   1   fetch has no instruction for cur_pc yet
//  ex_stall       in   1   EX stage stall
//  mem_stall      in   1   MEM stage stall
//  br_valid       in   1   branch resolved in ID this cycle (1-cycle pulse)
//  br_taken       in   1   resolved branch is taken; qualified by br_valid
//  br_target      in   32  taken-branch target; qualified by br_valid&br_taken
//  exc_valid      in   1   exception commit pulse
//  eret_valid     in   1   ERET commit pulse
//  epc            in   32  return PC for ERET
//  cur_pc         out  32  fetch PC presented to fetch unit
//  pc_delay_slot  out  1   instruction at cur_pc is a branch delay slot
//  pc_redirect    out  1   cur_pc was loaded non-sequentially last edge
//  pc_adel        out  1   cur_pc[1:0] != 0 (fetch address error)
//
// BEHAVIOUR
//  - advance = !if_stall & !ex_stall & !mem_stall (instruction leaves IF this cycle).
//  - States: SEQ (no pending branch), WAIT_DS (taken target latched in br_pend_pc;
//    delay slot, which is cur_pc, not yet consumed).
//  - Next-PC priority, highest first:
//    1 exc_valid : cur_pc<=EXC_VEC regardless of stalls; state<=SEQ; pending dropped.
//    2 eret_valid: cur_pc<=epc regardless of stalls; state<=SEQ; pending dropped.
//    3 WAIT_DS & advance: cur_pc<=br_pend_pc; state<=SEQ.
//    4 SEQ & br_valid & br_taken & advance: cur_pc<=br_target directly; stay SEQ.
//    5 SEQ & br_valid & br_taken & !advance: br_pend_pc<=br_target; state<=WAIT_DS;
//      cur_pc holds.
//    6 advance (no redirect pending): cur_pc<=cur_pc+4.
//    7 otherwise cur_pc holds.
//  - br_valid & !br_taken: no effect. br_valid while in WAIT_DS is illegal; ignored,
//    and flagged by a simulation-only assertion.
//  - pc_delay_slot (comb) = (state==WAIT_DS) | (state==SEQ & br_valid & br_taken).
//  - pc_redirect registered: 1 in the cycle after cases 1-4 load cur_pc, else 0.
//  - pc_adel (comb) = |cur_pc[1:0]; misaligned targets/EPC loaded unchanged;
//    sequential +4 still applied; handling is downstream.
//  - Arithmetic: 32-bit unsigned, cur_pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000.
//  - Reset (async, any time, incl. mid WAIT_DS): cur_pc=RESET_PC, state=SEQ,
//    br_pend_pc=0, pc_redirect=0; pc_delay_slot=0, pc_adel=0 follow combinationally.
//  - Latency: redirect visible on cur_pc one edge after its trigger; no bubbles
//    inserted by this block.
//
// TESTING
//  1 resetn=0 -> cur_pc=BFC00000, pc_redirect=0; release, no stalls ->
//    BFC00004, BFC00008 on next edges.
//  2 cur_pc=BFC00010, br_valid&taken tgt=BFC00100, no stall -> pc_delay_slot=1 that
//    cycle; next cur_pc=BFC00100, pc_redirect=1 for one cycle.
//  3 Same branch with if_stall=1 for 3 cycles -> cur_pc holds BFC00010 in WAIT_DS,
//    pc_delay_slot=1; stall drops -> cur_pc=BFC00100.
//  4 In WAIT_DS with mem_stall=1, exc_valid=1 -> cur_pc=BFC00380, state SEQ,
//    pending target dropped; next advance -> BFC00384.
//  5 exc_valid&eret_valid same cycle, epc=80001002 -> cur_pc=BFC00380; then eret
//    alone -> cur_pc=80001002, pc_adel=1.
//  6 cur_pc=FFFFFFFC, advance -> 00000000, pc_redirect=0; resetn pulsed mid WAIT_DS
//    -> cur_pc=BFC00000 immediately, pc_delay_slot=0.

Source files
------------

// File: rtl/pipe_pcu.sv
// PC generation stage feeding instruction fetch: sequential advance, taken branches
// with a MIPS delay slot, exception entry and ERET return.
module pipe_pcu #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter logic [31:0] EXC_VEC  = 32'hBFC0_0380
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        if_stall,
    input  logic        ex_stall,
    input  logic        mem_stall,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        exc_valid,
    input  logic        eret_valid,
    input  logic [31:0] epc,
    output logic [31:0] cur_pc,
    output logic        pc_delay_slot,
    output logic        pc_redirect,
    output logic        pc_adel
);

    typedef enum logic {
        SEQ     = 1'b0,
        WAIT_DS = 1'b1
    } pcu_state_e;

    pcu_state_e  state, state_next;
    logic [31:0] br_pend_pc, br_pend_pc_next;
    logic [31:0] pc_next;
    logic        redirect_next;
    logic        advance;
    logic        br_take_now;

    assign advance     = !if_stall && !ex_stall && !mem_stall;
    assign br_take_now = br_valid && br_taken;

    // NOTE: every signal written here gets a default first, so no path through
    // the priority chain can leave one unassigned and infer a latch.
    always_comb begin
        state_next      = state;
        pc_next         = cur_pc;
        br_pend_pc_next = br_pend_pc;
        redirect_next   = 1'b0;

        if (exc_valid) begin
            pc_next         = EXC_VEC;
            state_next      = SEQ;
            br_pend_pc_next = '0;
            redirect_next   = 1'b1;
        end else if (eret_valid) begin
            pc_next         = epc;
            state_next      = SEQ;
            br_pend_pc_next = '0;
            redirect_next   = 1'b1;
        end else if (state == WAIT_DS) begin
            // Delay slot leaves IF this cycle; the latched target follows it.
            if (advance) begin
                pc_next       = br_pend_pc;
                state_next    = SEQ;
                redirect_next = 1'b1;
            end
        end else if (br_take_now) begin
            if (advance) begin
                pc_next       = br_target;
                redirect_next = 1'b1;
            end else begin
                br_pend_pc_next = br_target;
                state_next      = WAIT_DS;
            end
        end else if (advance) begin
            pc_next = cur_pc + 32'd4;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= SEQ;
            cur_pc      <= RESET_PC;
            br_pend_pc  <= '0;
            pc_redirect <= 1'b0;
        end else begin
            state       <= state_next;
            cur_pc      <= pc_next;
            br_pend_pc  <= br_pend_pc_next;
            pc_redirect <= redirect_next;
        end
    end

    assign pc_delay_slot = (state == WAIT_DS) || ((state == SEQ) && br_take_now);
    assign pc_adel       = |cur_pc[1:0];

    // A second branch resolving before the delay slot has left IF is a pipeline bug upstream.
    a_no_branch_in_wait_ds: assert property (
        @(posedge clk) disable iff (!resetn) !((state == WAIT_DS) && br_valid)
    );

endmodule
